extremum_finder: RTL



---
 rtl/extremum_pkg.sv | 9 +
 rtl/extremum_finder_if.sv | 37 +++
 rtl/extremum_cmp2.sv | 38 +++
 rtl/extremum_finder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/extremum_pkg.sv
// Shared mode encoding for the extremum finder and its callers.
package extremum_pkg;

  typedef logic mode_t;

  localparam mode_t MODE_MIN = 1'b0;
  localparam mode_t MODE_MAX = 1'b1;

endpackage

// File: rtl/extremum_finder_if.sv
// Transaction bus of the extremum finder: lane vector in, winning lane out.
interface extremum_finder_if
  import extremum_pkg::*;
#(
  parameter int N_VALS    = 7,
  parameter int VAL_WIDTH = 9,
  parameter int TAG_WIDTH = 8
);

  localparam int IDX_W = $clog2(N_VALS);
  localparam int CNT_W = $clog2(N_VALS + 1);

  logic                             valid_in;
  logic [N_VALS-1:0][VAL_WIDTH-1:0] vals_in;
  logic [N_VALS-1:0]                mask_in;
  logic [CNT_W-1:0]                 count_in;
  mode_t                            mode_in;
  logic [TAG_WIDTH-1:0]             tag_in;

  logic                             valid_out;
  logic [IDX_W-1:0]                 index_out;
  logic [VAL_WIDTH-1:0]             value_out;
  logic                             found_out;
  mode_t                            mode_out;
  logic [TAG_WIDTH-1:0]             tag_out;

  modport master (
    output valid_in, vals_in, mask_in, count_in, mode_in, tag_in,
    input  valid_out, index_out, value_out, found_out, mode_out, tag_out
  );

  modport slave (
    input  valid_in, vals_in, mask_in, count_in, mode_in, tag_in,
    output valid_out, index_out, value_out, found_out, mode_out, tag_out
  );

endinterface

// File: rtl/extremum_cmp2.sv
// One tree node: picks the better of two candidates, ties going to the left (lower index).
module extremum_cmp2
  import extremum_pkg::*;
#(
  parameter int VAL_WIDTH = 9,
  parameter int IDX_W     = 3
) (
  input  mode_t                 mode_i,
  input  logic                  l_vld_i,
  input  logic [VAL_WIDTH-1:0]  l_val_i,
  input  logic [IDX_W-1:0]      l_idx_i,
  input  logic                  r_vld_i,
  input  logic [VAL_WIDTH-1:0]  r_val_i,
  input  logic [IDX_W-1:0]      r_idx_i,
  output logic                  vld_o,
  output logic [VAL_WIDTH-1:0]  val_o,
  output logic [IDX_W-1:0]      idx_o
);

  logic sel_r;

  always_comb begin
    sel_r = r_vld_i;
    if (l_vld_i && r_vld_i) begin
      sel_r = (mode_i == MODE_MAX) ? (r_val_i > l_val_i) : (r_val_i < l_val_i);
    end

    vld_o = l_vld_i || r_vld_i;
    val_o = sel_r ? r_val_i : l_val_i;
    idx_o = sel_r ? r_idx_i : l_idx_i;
    // Empty node: neutral value so an empty transaction reports it at the root.
    if (!l_vld_i && !r_vld_i) begin
      val_o = (mode_i == MODE_MAX) ? '0 : '1;
      idx_o = '0;
    end
  end

endmodule

// File: rtl/extremum_finder.sv
// Pipelined argmin/argmax over N_VALS lanes: input register, one register per tree
// level, then an output register; one transaction per cycle, no backpressure.
module extremum_finder
  import extremum_pkg::*;
#(
  parameter int N_VALS    = 7,
  parameter int VAL_WIDTH = 9,
  parameter int TAG_WIDTH = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  extremum_finder_if.slave  bus
);

  localparam int IDX_W = $clog2(N_VALS);
  localparam int D     = $clog2(N_VALS);
  localparam int NLEAF = 1 << D;
  localparam int NNODE = 2 * NLEAF - 1;

  typedef struct packed {
    logic                 vld;
    logic [VAL_WIDTH-1:0] value;
    logic [IDX_W-1:0]     index;
  } cand_t;

  // Heap layout: node 0 is the root, node n has children 2n+1 and 2n+2,
  // leaves occupy NLEAF-1 .. NNODE-1 and are all at the same depth.
  cand_t                node_d [NNODE];
  cand_t                node_q [NNODE];

  logic                 vld_p_q  [D+1];
  mode_t                mode_p_q [D+1];
  logic [TAG_WIDTH-1:0] tag_p_q  [D+1];

  logic                 valid_q;
  logic [IDX_W-1:0]     index_q;
  logic [VAL_WIDTH-1:0] value_q;
  logic                 found_q;
  mode_t                mode_q;
  logic [TAG_WIDTH-1:0] tag_q;

  // Stage 0: per-lane eligibility, padding leaves never eligible
  for (genvar j = 0; j < NLEAF; j++) begin : g_leaf
    if (j < N_VALS) begin : g_lane
      assign node_d[NLEAF-1+j] = {bus.mask_in[j] && (int'(bus.count_in) > j),
                                  bus.vals_in[j], IDX_W'(j)};
    end else begin : g_pad
      assign node_d[NLEAF-1+j] = {1'b0, {VAL_WIDTH{1'b0}}, IDX_W'(j)};
    end
  end

  // Stages 1..D: tree level lv is fed by stage lv-1 and uses that stage's mode
  for (genvar lv = 1; lv <= D; lv++) begin : g_lvl
    for (genvar k = 0; k < (1 << (D - lv)); k++) begin : g_node
      localparam int NI = (1 << (D - lv)) - 1 + k;
      logic                 c_vld;
      logic [VAL_WIDTH-1:0] c_val;
      logic [IDX_W-1:0]     c_idx;

      extremum_cmp2 #(
        .VAL_WIDTH (VAL_WIDTH),
        .IDX_W     (IDX_W)
      ) u_cmp (
        .mode_i  (mode_p_q[lv-1]),
        .l_vld_i (node_q[2*NI+1].vld),
        .l_val_i (node_q[2*NI+1].value),
        .l_idx_i (node_q[2*NI+1].index),
        .r_vld_i (node_q[2*NI+2].vld),
        .r_val_i (node_q[2*NI+2].value),
        .r_idx_i (node_q[2*NI+2].index),
        .vld_o   (c_vld),
        .val_o   (c_val),
        .idx_o   (c_idx)
      );

      assign node_d[NI] = {c_vld, c_val, c_idx};
    end
  end

  always_ff @(posedge clk_in) begin
    node_q      <= node_d;
    mode_p_q[0] <= bus.mode_in;
    tag_p_q[0]  <= bus.tag_in;
    for (int s = 1; s <= D; s++) begin
      mode_p_q[s] <= mode_p_q[s-1];
      tag_p_q[s]  <= tag_p_q[s-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int s = 0; s <= D; s++) vld_p_q[s] <= 1'b0;
    end else begin
      vld_p_q[0] <= bus.valid_in;
      for (int s = 1; s <= D; s++) vld_p_q[s] <= vld_p_q[s-1];
    end
  end

  // Output stage: data only updates with a valid result and holds otherwise
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      index_q <= '0;
      value_q <= '0;
      found_q <= 1'b0;
      mode_q  <= MODE_MIN;
      tag_q   <= '0;
    end else begin
      valid_q <= vld_p_q[D];
      if (vld_p_q[D]) begin
        index_q <= node_q[0].index;
        value_q <= node_q[0].value;
        found_q <= node_q[0].vld;
        mode_q  <= mode_p_q[D];
        tag_q   <= tag_p_q[D];
      end
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.index_out = index_q;
  assign bus.value_out = value_q;
  assign bus.found_out = found_q;
  assign bus.mode_out  = mode_q;
  assign bus.tag_out   = tag_q;

endmodule
